axi4_master: RTL
================

AXI4_MASTER -- requirements
Module: axi4_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, driven on arid/awid/wid.
REQ-002 SHALL have parameter MAX_LEN, default 8'd7, the largest accepted req_len (beats-1).
REQ-003 aclk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 req_valid/req_ready  input/output  1/1  request handshake.
REQ-006 req_wen  input  1  1=write, 0=read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_len/req_size  input  8/3  read beats-1 and AXI size; writes always single-beat, size 3'd3.
REQ-009 req_wdata/req_wstrb  input  64/8  write data and byte strobes.
REQ-010 rsp_valid  output  1  one-cycle pulse per read beat, or one pulse on write completion.
REQ-011 rsp_data/rsp_last/rsp_err  output  64/1/1  beat data, final-beat flag, error flag.
REQ-012 AXI4 master ports: ar{addr,id,len,size,burst,lock,cache,prot,valid}/arready; r{id,data,resp,last,valid}/rready; aw{addr,id,len,size,burst,lock,cache,prot,valid}/awready; w{id,data,strb,last,valid}/wready; b{id,resp,valid}/bready; widths 32/4/8/3/2/2/4/3, data 64, strb 8, resp 2.

Function
REQ-013 FSM states IDLE, AR, R, AW_W, B; req_ready=1 only in IDLE; at most one outstanding transaction.
REQ-014 IDLE: on req_valid&req_ready, latch request; read -> AR, write -> AW_W; arvalid/awvalid asserted the cycle after acceptance (registered outputs).
REQ-015 req_len > MAX_LEN on a read SHALL be clamped to MAX_LEN and rsp_err SHALL be set on the last beat.
REQ-016 AR: arvalid=1 with latched addr/len/size, arburst=2'b01 (INCR), arlock/arcache/arprot=0; arvalid and payload stable until arready; on handshake -> R.
REQ-017 R: rready=1 constantly; each rvalid beat -> rsp_valid=1 next cycle with registered rdata, beat counter increments (8-bit).
REQ-018 R: rlast terminates the burst -> IDLE; rsp_last=1 on that beat; rsp_err=1 if beat count != len+1, any rresp != 2'b00 in the burst (sticky), or rid != AXI_ID.
REQ-019 AW_W: awvalid and wvalid asserted together, awlen=0, awsize=3'd3, wlast=1; each deasserted independently on its own handshake; -> B when both done (same or different cycles, either order).
REQ-020 B: bready=1; on bvalid -> rsp_valid=1 next cycle, rsp_last=1, rsp_err=(bresp!=0)|(bid!=AXI_ID), -> IDLE.
REQ-021 rvalid/bvalid outside R/B SHALL be ignored (rready/bready=0 there).
REQ-022 Minimum read latency: accept cycle N, arvalid N+1, arready N+1, first rvalid N+2, rsp_valid N+3.
REQ-023 rsp_valid is a pulse with no backpressure; rsp_data/rsp_last/rsp_err are valid only while rsp_valid=1.

Reset
REQ-024 aresetn=0 SHALL force IDLE, counter 0, sticky error 0, all valid/ready outputs 0 (req_ready=1 the cycle after release).
REQ-025 Reset mid-transaction SHALL abandon it without any rsp_valid; the slave is also reset by the same aresetn.
REQ-026 Payload registers (addr, data) need no reset.

Structure
REQ-027 Shared package axi_pkg SHALL hold BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_8B=3'd3, and the FSM state enum.
REQ-028 Single module; no sub-modules.

Verification
REQ-029 Read, addr 0x80000000, len 3, size 3, slave returns beats 0x11..0x44 with OKAY -> four rsp_valid pulses, data 0x11,0x22,0x33,0x44, rsp_last only on fourth, rsp_err=0.
REQ-030 Write, addr 0x80000010, wdata 0xDEADBEEF, wstrb 0x0F; slave takes awready 3 cycles after wready -> one AW and one W handshake each, single rsp_valid with rsp_err=0.
REQ-031 Read len 1, slave returns rlast on beat 1 -> rsp_last on beat 1, rsp_err=1; FSM back in IDLE.
REQ-032 Read len 0, rresp=2'b10 -> single pulse, rsp_last=1, rsp_err=1.
REQ-033 aresetn low while in R after 2 beats -> no further rsp_valid, all AXI valids 0, req_ready=1 after release.
REQ-034 req_valid held high during active write -> second request accepted only in the cycle after the write completes.

Source files
------------

// File: rtl/axi_pkg.sv
// ============================================================================
// axi_pkg : AXI4 encodings and master FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axi4_master.sv
// ============================================================================
// axi4_master : single-outstanding AXI4 master (burst reads, single-beat writes)
// Rev 1.0
// ============================================================================
`default_nettype none

module axi4_master
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,

    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,

    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    state_t      w_next;

    logic        r_rst_done;
    logic        r_aw_done;
    logic        r_w_done;
    logic [7:0]  r_cnt;
    logic        r_err_sticky;
    logic        r_rsp_valid;
    logic        r_rsp_last;
    logic        r_rsp_err;

    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic        r_clamp;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [63:0] r_rsp_data;

    logic        w_accept;
    logic        w_ar_fire;
    logic        w_r_fire;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_b_fire;
    logic        w_beat_err;

    // req_ready is held low for the whole reset and rises one cycle after release
    assign req_ready = (r_state == ST_IDLE) & r_rst_done;
    assign w_accept  = req_valid & req_ready;

    assign arvalid = (r_state == ST_AR);
    assign araddr  = r_addr;
    assign arid    = AXI_ID;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign rready  = (r_state == ST_R);

    assign awvalid = (r_state == ST_AW_W) & ~r_aw_done;
    assign awaddr  = r_addr;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = SIZE_8B;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wvalid  = (r_state == ST_AW_W) & ~r_w_done;
    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;

    assign bready  = (r_state == ST_B);

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign rsp_err   = r_rsp_err;

    assign w_ar_fire  = arvalid & arready;
    assign w_r_fire   = rvalid & rready;
    assign w_aw_fire  = awvalid & awready;
    assign w_w_fire   = wvalid & wready;
    assign w_b_fire   = bvalid & bready;
    assign w_beat_err = (rresp != RESP_OKAY) | (rid != AXI_ID);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = req_wen ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (w_ar_fire) begin
                    w_next = ST_R;
                end
            end
            ST_R: begin
                if (w_r_fire && rlast) begin
                    w_next = ST_IDLE;
                end
            end
            ST_AW_W: begin
                // AW and W may complete in the same cycle or in either order
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next = ST_B;
                end
            end
            ST_B: begin
                if (w_b_fire) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rst_done   <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_cnt        <= 8'd0;
            r_err_sticky <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rst_done  <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            if (w_accept) begin
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
                r_cnt        <= 8'd0;
                r_err_sticky <= 1'b0;
            end
            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end
            if (w_r_fire) begin
                r_cnt        <= r_cnt + 8'd1;
                r_err_sticky <= r_err_sticky | w_beat_err;
                r_rsp_valid  <= 1'b1;
                r_rsp_last   <= rlast;
                // r_cnt is the index of this beat, so a full burst ends with r_cnt == r_len
                r_rsp_err    <= rlast & (r_clamp | (r_cnt != r_len) | r_err_sticky | w_beat_err);
            end
            if (w_b_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_last  <= 1'b1;
                r_rsp_err   <= (bresp != RESP_OKAY) | (bid != AXI_ID);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (req_len > MAX_LEN) begin
                r_len   <= MAX_LEN;
                r_clamp <= 1'b1;
            end else begin
                r_len   <= req_len;
                r_clamp <= 1'b0;
            end
        end
        if (w_r_fire) begin
            r_rsp_data <= rdata;
        end else if (w_b_fire) begin
            r_rsp_data <= 64'd0;
        end
    end

endmodule

`default_nettype wire
